bt_serial_trit_decoder: RTL and testbench

//  Serial balanced-ternary to binary decoder: the read side of the 2-bit trit encoding driven

---
 rtl/bt_serial_trit_decoder.sv | 109 ++++++++++
 tb/tb_bt_serial_trit_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bt_serial_trit_decoder.sv
// Serial balanced-ternary (2-bit trit code) to signed binary decoder.
// Trits arrive MSB-first; the finished word is held until the consumer takes it.
module bt_serial_trit_decoder #(
  parameter int NTRITS = 4,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_trit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic             out_err
);

  function automatic longint pow3(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 3;
    return r;
  endfunction

  localparam longint MAX_MAG = (pow3(NTRITS) - 1) / 2;
  localparam longint OUT_LIM = longint'(1) << (OUT_W - 1);
  localparam int     CNT_W   = $clog2(NTRITS + 1);

  generate
    if (NTRITS < 2 || NTRITS > 8) begin : g_bad_ntrits
      $error("bt_serial_trit_decoder: NTRITS must be 2..8");
    end
    if (OUT_LIM <= MAX_MAG) begin : g_bad_out_w
      $error("bt_serial_trit_decoder: OUT_W too narrow for NTRITS");
    end
  endgenerate

  typedef enum logic {ACCUM, DONE} state_t;

  state_t             state;
  logic [OUT_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               err;
  logic [OUT_W+1:0]   acc_ext, trit_val, acc_nxt;
  logic               accept;

  assign accept = in_valid && in_ready;

  // acc*3 + t formed two bits wide so the intermediate sum never wraps
  always_comb begin
    trit_val = '0;
    case (in_trit)
      2'b10:   trit_val = {{(OUT_W+1){1'b0}}, 1'b1};
      2'b01:   trit_val = '1;
      default: trit_val = '0;
    endcase
    acc_ext = {{2{acc[OUT_W-1]}}, acc};
    acc_nxt = (acc_ext << 1) + acc_ext + trit_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_nxt[OUT_W-1:0];
            cnt <= cnt + 1'b1;
            if (in_trit == 2'b00) err <= 1'b1;
            if (cnt == CNT_W'(NTRITS - 1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // in_ready stays low through the take cycle, so no trit slips in
          if (out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign out_value = acc;
  assign out_err   = err;

endmodule

// File: tb/tb_bt_serial_trit_decoder.sv
// Randomized self-checking bench for bt_serial_trit_decoder (NTRITS=4, OUT_W=8).
module tb_bt_serial_trit_decoder;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         flush = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [1:0]   in_trit = 2'b11;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] out_value;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  bt_serial_trit_decoder #(.NTRITS(N), .OUT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_trit(in_trit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 5000000)", $time);
    $fatal(1, "watchdog");
  end

  // Reference: word value as a weighted sum of digits, first trit has weight 3^(N-1)
  function automatic int trit_digit(input logic [1:0] c);
    case (c)
      2'b10:   return 1;
      2'b01:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_value(input logic [N-1:0][1:0] w);
    int v = 0;
    for (int i = 0; i < N; i++) v += trit_digit(w[i]) * (3 ** i);
    return W'(v);
  endfunction

  function automatic logic ref_err(input logic [N-1:0][1:0] w);
    for (int i = 0; i < N; i++) if (w[i] == 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic drive_trit(input logic [1:0] c, input int gap);
    int n = 0;
    repeat (gap) begin in_valid = 0; @(negedge clk); end
    in_valid = 1; in_trit = c;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL trit_accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic send_word(input logic [N-1:0][1:0] w, input int maxgap);
    for (int i = N - 1; i >= 0; i--) drive_trit(w[i], $urandom_range(maxgap, 0));
  endtask

  task automatic take(input int delay, output logic vld, output logic [W-1:0] v, output logic e);
    repeat (delay) @(negedge clk);
    vld = out_valid; v = out_value; e = out_err;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_value, out_err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b value=%h err=%0b ready=%0b, required 0 00 0 1",
               out_valid, out_value, out_err, in_ready);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [N-1:0][1:0] w [6];
    logic [W-1:0] exp_v [6];
    logic         exp_e [6];
    logic vld, e; logic [W-1:0] v;
    w[0] = {2'b11, 2'b01, 2'b11, 2'b10}; exp_v[0] = 8'hF8; exp_e[0] = 0;
    w[1] = {2'b11, 2'b11, 2'b11, 2'b01}; exp_v[1] = 8'hFF; exp_e[1] = 0;
    w[2] = {2'b10, 2'b10, 2'b10, 2'b10}; exp_v[2] = 8'h28; exp_e[2] = 0;
    w[3] = {2'b01, 2'b01, 2'b01, 2'b01}; exp_v[3] = 8'hD8; exp_e[3] = 0;
    w[4] = {2'b10, 2'b00, 2'b11, 2'b10}; exp_v[4] = 8'h1C; exp_e[4] = 1;
    w[5] = {2'b11, 2'b11, 2'b11, 2'b10}; exp_v[5] = 8'h01; exp_e[5] = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = N - 1; i >= 0; i--) begin
        drive_trit(w[k][i], 0);
        checks++;
        if (out_valid !== (i == 0)) begin
          errors++;
          $display("FAIL vec%0d_valid_timing trit %0d: out_valid=%0b, required %0b",
                   k, N - 1 - i, out_valid, (i == 0));
        end
      end
      take(0, vld, v, e);
      checks++;
      if ({v, e} !== {exp_v[k], exp_e[k]}) begin
        errors++;
        $display("FAIL vec%0d_result: value=%h err=%0b, required %h %0b", k, v, e, exp_v[k], exp_e[k]);
      end
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL vec%0d_after_take: valid=%0b ready=%0b, required 0 1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic vld, e; logic [W-1:0] v;
    logic [N-1:0][1:0] w = {2'b10, 2'b01, 2'b10, 2'b11};
    send_word(w, 0);
    in_valid = 1; in_trit = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_value} !== {1'b0, 1'b1, ref_value(w)}) begin
        errors++;
        $display("FAIL hold_cycle%0d: ready=%0b valid=%0b value=%h, required 0 1 %h",
                 c, in_ready, out_valid, out_value, ref_value(w));
      end
    end
    in_valid = 0;
    take(0, vld, v, e);
    w = {2'b01, 2'b11, 2'b10, 2'b10};
    send_word(w, 1);
    take(0, vld, v, e);
    checks++;
    if ({vld, v, e} !== {1'b1, ref_value(w), 1'b0}) begin
      errors++;
      $display("FAIL after_hold_word: valid=%0b value=%h err=%0b, required 1 %h 0", vld, v, e, ref_value(w));
    end
  endtask

  task automatic test_flush();
    logic vld, e; logic [W-1:0] v;
    logic [N-1:0][1:0] w = {2'b10, 2'b11, 2'b01, 2'b10};
    // mid-word flush
    drive_trit(2'b10, 0); drive_trit(2'b00, 0);
    flush = 1; @(negedge clk); flush = 0;
    send_word(w, 0);
    take(0, vld, v, e);
    checks++;
    if ({vld, v, e} !== {1'b1, ref_value(w), 1'b0}) begin
      errors++;
      $display("FAIL flush_midword: valid=%0b value=%h err=%0b, required 1 %h 0", vld, v, e, ref_value(w));
    end
    // flush in DONE discards the pending result
    send_word(w, 0);
    flush = 1; @(negedge clk); flush = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_done: valid=%0b ready=%0b, required 0 1", out_valid, in_ready);
    end
    // flush wins over a same-cycle accept
    in_valid = 1; in_trit = 2'b10; flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    w = {2'b01, 2'b10, 2'b11, 2'b01};
    send_word(w, 0);
    take(0, vld, v, e);
    checks++;
    if ({vld, v, e} !== {1'b1, ref_value(w), 1'b0}) begin
      errors++;
      $display("FAIL flush_with_accept: valid=%0b value=%h err=%0b, required 1 %h 0", vld, v, e, ref_value(w));
    end
  endtask

  task automatic test_async_reset();
    logic vld, e; logic [W-1:0] v;
    logic [N-1:0][1:0] w = {2'b11, 2'b10, 2'b00, 2'b01};
    drive_trit(2'b10, 0); drive_trit(2'b10, 0); drive_trit(2'b00, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, out_value, out_err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: valid=%0b value=%h err=%0b ready=%0b, required 0 00 0 1",
               out_valid, out_value, out_err, in_ready);
    end
    @(negedge clk); rst_n = 1; @(negedge clk);
    send_word(w, 0);
    take(0, vld, v, e);
    checks++;
    if ({vld, v, e} !== {1'b1, ref_value(w), 1'b1}) begin
      errors++;
      $display("FAIL after_async_reset: valid=%0b value=%h err=%0b, required 1 %h 1", vld, v, e, ref_value(w));
    end
  endtask

  task automatic test_random();
    logic vld, e; logic [W-1:0] v;
    logic [N-1:0][1:0] w;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < N; i++) w[i] = ($urandom_range(15, 0) == 0) ? 2'b00 : 2'($urandom_range(3, 1));
      send_word(w, 2);
      take($urandom_range(3, 0), vld, v, e);
      checks++;
      if ({vld, v, e} !== {1'b1, ref_value(w), ref_err(w)}) begin
        errors++;
        $display("FAIL random_word%0d: valid=%0b value=%h err=%0b, required 1 %h %0b",
                 k, vld, v, e, ref_value(w), ref_err(w));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
